regfile_sync_rw: RTL

- Parametrised successor to the pipeline's two-read/one-write register file. Sits in the ID stage of the MIPS pipeline; the WB stage drives the write port.
- Reads are registered, with a stall enable, and are serviced on every cycle, including cycles that carry a write.
- Reset starts a hardware scrub state machine that clears one entry per cycle, so the array maps onto block or distributed RAM instead of a flop bank with a global clear.

---
 rtl/regfile_sync_rw_if.sv | 26 ++
 rtl/regfile_sync_rw.sv | 129 ++++++++++++
 2 files changed

// File: rtl/regfile_sync_rw_if.sv
// Register-file access bus: two registered read ports, one write port, scrub status.
// The master drives addresses, enables and write data; the slave returns read data and init_busy.
interface regfile_sync_rw_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wdata;
    logic              init_busy;

    modport master (
        output rd_en, ra1, ra2, we, wa, wdata,
        input  rdata1, rdata2, init_busy
    );

    modport slave (
        input  rd_en, ra1, ra2, we, wa, wdata,
        output rdata1, rdata2, init_busy
    );
endinterface

// File: rtl/regfile_sync_rw.sv
// Two-read/one-write register file with registered reads and a post-reset scrub FSM.
// Define REGFILE_BYPASS_EN for write-first forwarding; otherwise reads return the old contents.
module regfile_sync_rw #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input logic              clk,
    input logic              rst_n,
    regfile_sync_rw_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic              init_busy;

    logic [DATA_W-1:0] rf [DEPTH];
    logic              arr_we;
    logic [ADDR_W-1:0] arr_wa;
    logic [DATA_W-1:0] arr_wd;
    logic              wr_ok;

    logic [DATA_W-1:0] rd1_word, rd2_word;
    logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        unique case (state_q)
            StInit: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
        endcase
    end

    // A write to the hardwired zero entry is dropped entirely, including its forwarding.
    assign wr_ok = bus.we && !((ZERO_REG != 0) && (bus.wa == '0));

    always_comb begin
        init_busy = 1'b0;
        arr_we    = 1'b0;
        arr_wa    = bus.wa;
        arr_wd    = bus.wdata;
        unique case (state_q)
            StInit: begin
                init_busy = 1'b1;
                arr_we    = 1'b1;
                arr_wa    = init_ptr_q;
                arr_wd    = '0;
            end
            StRun: begin
                arr_we = wr_ok;
            end
        endcase
    end

    // No reset on the array itself so it can map onto RAM; the reset cycle leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst_n && arr_we) begin
            rf[arr_wa] <= arr_wd;
        end
    end

    always_comb begin
        rd1_word = rf[bus.ra1];
        rd2_word = rf[bus.ra2];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.wa == bus.ra1)) begin
            rd1_word = bus.wdata;
        end
        if (wr_ok && (bus.wa == bus.ra2)) begin
            rd2_word = bus.wdata;
        end
`endif
        if ((ZERO_REG != 0) && (bus.ra1 == '0)) begin
            rd1_word = '0;
        end
        if ((ZERO_REG != 0) && (bus.ra2 == '0)) begin
            rd2_word = '0;
        end
    end

    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (bus.rd_en) begin
            if (state_q == StInit) begin
                rdata1_d = '0;
                rdata2_d = '0;
            end else begin
                rdata1_d = rd1_word;
                rdata2_d = rd2_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    assign bus.rdata1    = rdata1_q;
    assign bus.rdata2    = rdata2_q;
    assign bus.init_busy = init_busy;
endmodule
